// File: rtl/waveguide_slot_scheduler_if.sv
// Handshake bundle between the routers/waveguide and the slot scheduler.
// The router side drives request/done. The scheduler side drives the grant outputs.
interface waveguide_slot_scheduler_if #(
  parameter int NUM_ROUTERS = 2,
  parameter int ID_W        = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1
);
  logic [NUM_ROUTERS-1:0] request;
  logic [NUM_ROUTERS-1:0] done;
  logic [NUM_ROUTERS-1:0] grant;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic                   timeout_pulse;

  modport master (
    output request,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout_pulse
  );

  modport slave (
    input  request,
    input  done,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout_pulse
  );
endinterface

// File: rtl/waveguide_slot_scheduler.sv
// Round-robin owner selection for the shared bidirectional waveguide.
// A grant is held until the owner's packet_done arrives or the hold limit is reached.
// A guard interval then lets in-flight light drain before the next owner is granted.
module waveguide_slot_scheduler #(
  parameter int NUM_ROUTERS  = 2,
  parameter int GUARD_CYCLES = 4,
  parameter int MAX_HOLD     = 16
) (
  input logic                    clk,
  input logic                    rst,
  waveguide_slot_scheduler_if.slave bus
);

  localparam int ID_W    = (NUM_ROUTERS > 1) ? $clog2(NUM_ROUTERS) : 1;
  localparam int HOLD_W  = ($clog2(MAX_HOLD + 1) > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GUARD_W = ($clog2(GUARD_CYCLES + 1) > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
  localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_ROUTERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t                 state_r;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [GUARD_W-1:0]     guard_cnt_r;
  logic [NUM_ROUTERS-1:0] grant_r;
  logic                   grant_valid_r;
  logic [ID_W-1:0]        grant_id_r;
  logic                   timeout_pulse_r;

  logic                   sel_found_s;
  logic [ID_W-1:0]        sel_id_s;
  logic                   owner_done_s;
  logic                   hold_last_s;
  logic [ID_W-1:0]        next_ptr_s;

  assign bus.grant         = grant_r;
  assign bus.grant_valid   = grant_valid_r;
  assign bus.grant_id      = grant_id_r;
  assign bus.timeout_pulse = timeout_pulse_r;

  // Find the first requester at or above rr_ptr, wrapping around the ring.
  always_comb begin
    sel_found_s = 1'b0;
    sel_id_s    = '0;
    for (int i = 0; i < NUM_ROUTERS; i++) begin
      int idx;
      idx = int'(rr_ptr_r) + i;
      if (idx >= NUM_ROUTERS) begin
        idx = idx - NUM_ROUTERS;
      end else begin
        idx = idx;
      end
      if (!sel_found_s && bus.request[idx]) begin
        sel_found_s = 1'b1;
        sel_id_s    = ID_W'(idx);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  // Release conditions and the pointer value that follows the current owner.
  always_comb begin
    owner_done_s = bus.done[grant_id_r];
    hold_last_s  = (hold_cnt_r == HOLD_LAST);
    if (grant_id_r == LAST_ID) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = grant_id_r + ID_W'(1);
    end
  end

  // Scheduler FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      rr_ptr_r        <= '0;
      hold_cnt_r      <= '0;
      guard_cnt_r     <= '0;
      grant_r         <= '0;
      grant_valid_r   <= 1'b0;
      grant_id_r      <= '0;
      timeout_pulse_r <= 1'b0;
    end else begin
      timeout_pulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (sel_found_s) begin
            grant_r       <= NUM_ROUTERS'(1) << sel_id_s;
            grant_valid_r <= 1'b1;
            grant_id_r    <= sel_id_s;
            hold_cnt_r    <= '0;
            state_r       <= GRANT;
          end
        end
        GRANT: begin
          if (owner_done_s || hold_last_s) begin
            grant_r         <= '0;
            grant_valid_r   <= 1'b0;
            grant_id_r      <= '0;
            rr_ptr_r        <= next_ptr_s;
            hold_cnt_r      <= '0;
            // A done in the same cycle as the limit counts as a normal completion.
            timeout_pulse_r <= !owner_done_s;
            guard_cnt_r     <= '0;
            if (GUARD_CYCLES > 0) begin
              state_r <= GUARD;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end
        end
        GUARD: begin
          if (guard_cnt_r == GUARD_LAST) begin
            guard_cnt_r <= '0;
            state_r     <= IDLE;
          end else begin
            guard_cnt_r <= guard_cnt_r + GUARD_W'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= '0;
          grant_valid_r <= 1'b0;
          grant_id_r    <= '0;
          hold_cnt_r    <= '0;
          guard_cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule
